// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and event-decode an active-low push-button.
// Latency: press/release confirmed DEB_CYC+1 edges after the first edge sampling the new level.
// Backpressure: none; the outputs are single-cycle pulses and a level, with no flow control.
//
// Ports:
//   I_10m_clk      system clock, all logic on the rising edge
//   I_rst_n        asynchronous active-low reset (deassertion must meet recovery timing)
//   I_key_n        raw button, low = pressed, asynchronous to the clock
//   O_key_state    debounced level, 1 = pressed
//   O_key_press    one-cycle pulse on confirmed press
//   O_key_release  one-cycle pulse on confirmed release
//   O_key_long     one-cycle pulse once a confirmed hold has accumulated LONG_CYC pressed cycles
//
// DEB_CYC and LONG_CYC (derived below) must both be at least 2.
module key_debounce #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic I_10m_clk,
    input  logic I_rst_n,
    input  logic I_key_n,
    output logic O_key_state,
    output logic O_key_press,
    output logic O_key_release,
    output logic O_key_long
);

    localparam int DEB_CYC  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_MS;
    localparam int DEB_W    = $clog2(DEB_CYC + 1);
    localparam int LONG_W   = $clog2(LONG_CYC + 1);

    // Terminal counts: the counters start at 1 (debounce) or 0 (long) on entry,
    // so reaching N-1 on a qualifying edge means N qualifying samples in total.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. The key is inverted before the first flop so
    // that everything downstream works in "1 = pressed" terms and the
    // reset value 0 means "not pressed".
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic s_sync;

    always_ff @(posedge I_10m_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~I_key_n;
            sync2_q <= sync1_q;
        end
    end

    assign s_sync = sync2_q;

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [DEB_W-1:0]    deb_cnt_q,   deb_cnt_d;
    logic [LONG_W-1:0]   long_cnt_q,  long_cnt_d;
    logic                long_done_q, long_done_d;
    logic                key_state_q, key_state_d;
    logic                press_q,     press_d;
    logic                release_q,   release_d;
    logic                long_q,      long_d;

    always_ff @(posedge I_10m_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic. Pulse outputs default to 0 every cycle,
    // which makes them self-clearing; each pulse is produced from a
    // distinct state/condition so two pulse types can never coincide.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_sync) begin
                    state_d   = PRESS_FILT;
                    deb_cnt_d = DEB_ONE;
                end
            end

            PRESS_FILT: begin
                if (!s_sync) begin
                    // Too short to be a press: drop it silently.
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = DOWN;
                    press_d     = 1'b1;
                    key_state_d = 1'b1;
                    long_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            DOWN: begin
                if (!s_sync) begin
                    state_d   = REL_FILT;
                    deb_cnt_d = DEB_ONE;
                end else if (!long_done_q) begin
                    if (long_cnt_q == LONG_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        long_cnt_d = long_cnt_q + LONG_ONE;
                    end
                end
            end

            REL_FILT: begin
                if (s_sync) begin
                    // Release glitch: back to DOWN with the hold count intact.
                    // The hold counter only freezes on the cycles where the key
                    // reads released; this returning edge sees the key pressed
                    // and counts like any DOWN cycle, so each REL_FILT cycle
                    // postpones the long-press pulse by exactly one cycle.
                    state_d = DOWN;
                    if (!long_done_q) begin
                        if (long_cnt_q == LONG_LAST) begin
                            long_d      = 1'b1;
                            long_done_d = 1'b1;
                        end else begin
                            long_cnt_d = long_cnt_q + LONG_ONE;
                        end
                    end
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign O_key_state   = key_state_q;
    assign O_key_press   = press_q;
    assign O_key_release = release_q;
    assign O_key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomised stimulus for key_debounce, checked every cycle
// against a run-length reference model, plus edge-number checks for the directed scenarios.
// Clock period 10, inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk;
    logic I_rst_n;
    logic I_key_n;
    logic O_key_state;
    logic O_key_press;
    logic O_key_release;
    logic O_key_long;

    key_debounce #(
        .CLK_FREQ_HZ(1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20)
    ) dut (
        .I_10m_clk    (clk),
        .I_rst_n      (I_rst_n),
        .I_key_n      (I_key_n),
        .O_key_state  (O_key_state),
        .O_key_press  (O_key_press),
        .O_key_release(O_key_release),
        .O_key_long   (O_key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int ecnt   = 0;

    // Reference model state: delayed samples of "pressed", confirmed level,
    // length of the current run disagreeing with the level, and pressed-sample
    // count accumulated since the press was confirmed.
    logic h1, h2;
    logic m_level, m_press, m_rel, m_long;
    int   m_run, m_hold;
    bit   m_long_done;

    // Observations of DUT pulse edges within the current scenario.
    int press_edge, release_edge, long_edge, state_rise_edge;
    int n_press, n_release, n_long;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, ecnt, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h1 = 1'b0; h2 = 1'b0;
        m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        m_run = 0; m_hold = 0; m_long_done = 1'b0;
    endtask

    task automatic clr_obs();
        press_edge = -1; release_edge = -1; long_edge = -1; state_rise_edge = -1;
        n_press = 0; n_release = 0; n_long = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_state"},   O_key_state,   m_level);
        chk({tag, "_press"},   O_key_press,   m_press);
        chk({tag, "_release"}, O_key_release, m_rel);
        chk({tag, "_long"},    O_key_long,    m_long);
    endtask

    // One clock: drive the key, advance the model on the edge, check after it.
    task automatic step(input logic key);
        logic s;
        logic prev_state;
        I_key_n = key;
        prev_state = O_key_state;
        @(posedge clk);
        ecnt++;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        if (!I_rst_n) begin
            model_reset();
        end else begin
            // The decision logic sees the key as sampled two edges earlier.
            s  = h2;
            h2 = h1;
            h1 = ~key;
            if (s != m_level) m_run++;
            else              m_run = 0;
            if (m_run == DEB) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_press = 1'b1; m_hold = 0; m_long_done = 1'b0;
                end else begin
                    m_rel = 1'b1;
                end
            end else if (m_level && s && !m_long_done) begin
                m_hold++;
                if (m_hold == LONG) begin
                    m_long = 1'b1; m_long_done = 1'b1;
                end
            end
        end
        #1;
        check_outputs("cyc");
        if (O_key_press)   begin press_edge   = ecnt; n_press++;   end
        if (O_key_release) begin release_edge = ecnt; n_release++; end
        if (O_key_long)    begin long_edge    = ecnt; n_long++;    end
        if (O_key_state && !prev_state) state_rise_edge = ecnt;
    endtask

    task automatic steps(input logic key, input int n);
        for (int i = 0; i < n; i++) step(key);
    endtask

    initial begin
        I_key_n = 1'b1;
        I_rst_n = 1'b1;
        model_reset();
        clr_obs();

        // Reset values
        #2 I_rst_n = 1'b0;
        #1;
        check_outputs("reset");
        @(posedge clk); @(posedge clk);
        #1 I_rst_n = 1'b1;
        steps(1'b1, 5);

        // Clean press then clean release
        clr_obs(); ecnt = -1;
        steps(1'b0, 10);
        steps(1'b1, 10);
        chk_int("clean_press_edge", press_edge, 5);
        chk_int("clean_state_rise_edge", state_rise_edge, 5);
        chk_int("clean_release_edge", release_edge, 15);
        chk_int("clean_long_count", n_long, 0);

        // Press glitch shorter than the debounce window
        clr_obs(); ecnt = -1;
        steps(1'b0, 3);
        steps(1'b1, 10);
        chk_int("glitch_press_count", n_press, 0);
        chk_int("glitch_release_count", n_release, 0);
        chk_int("glitch_state_rise", state_rise_edge, -1);

        // Long press
        clr_obs(); ecnt = -1;
        steps(1'b0, 40);
        steps(1'b1, 10);
        chk_int("long_press_edge", press_edge, 5);
        chk_int("long_long_edge", long_edge, 25);
        chk_int("long_long_count", n_long, 1);
        chk_int("long_release_edge", release_edge, 45);

        // Release bounce while held
        clr_obs(); ecnt = -1;
        steps(1'b0, 12);
        steps(1'b1, 2);
        steps(1'b0, 30);
        steps(1'b1, 10);
        chk_int("bounce_long_edge", long_edge, 27);
        chk_int("bounce_release_count", n_release, 1);
        chk_int("bounce_release_edge", release_edge, 49);

        // Reset while held, key still held at reset release
        clr_obs(); ecnt = -1;
        steps(1'b0, 11);
        I_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        steps(1'b0, 2);
        I_rst_n = 1'b1;
        clr_obs(); ecnt = -1;
        steps(1'b0, 10);
        steps(1'b1, 10);
        chk_int("rst_repress_edge", press_edge, 5);
        chk_int("rst_release_edge", release_edge, 15);

        // Randomised bouncing key: mixture of short glitches and long holds
        begin
            logic lvl;
            lvl = 1'b1;
            for (int r = 0; r < 60; r++) begin
                int len;
                lvl = ~lvl;
                if ($urandom_range(0, 2) == 0) len = $urandom_range(25, 35);
                else                           len = $urandom_range(1, DEB + 2);
                steps(lvl, len);
            end
            steps(1'b1, 10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
